// File: rtl/seg7_scan_driver.sv
// Purpose: scans four BCD digits onto a 4-digit common-anode 7-segment display (blanking, dp, blink).
// Latency: pins follow scan/shadow/control state one clock later; digits are re-latched once per frame.
// Backpressure: none; free-running scan, seg1..seg4 are sampled only at frame boundaries.
module seg7_scan_driver #(
  parameter int DIGIT_TICKS  = 100_000,  // clocks each digit is driven, >= 2
  parameter int BLINK_FRAMES = 125       // full frames per blink half-period, >= 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] seg1,        // tens of seconds, leftmost
  input  logic [3:0] seg2,        // units of seconds
  input  logic [3:0] seg3,        // tens of hundredths
  input  logic [3:0] seg4,        // units of hundredths, rightmost
  input  logic       display_en,
  input  logic       dp_en,
  input  logic       blank_lz,
  input  logic       blink_en,
  output logic [3:0] an,          // active-low, an[3] = seg1 ... an[0] = seg4
  output logic [6:0] cathode,     // active-low {g,f,e,d,c,b,a}
  output logic       dp,          // active-low
  output logic       frame_tick
);

  // Counter widths; a one-bit floor keeps degenerate parameter values legal.
  localparam int TICK_W  = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(DIGIT_TICKS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  localparam logic [6:0] SEG_DARK = 7'b1111111;
  localparam logic [3:0] AN_DARK  = 4'b1111;

  // Refuse to elaborate with parameters the scan timing cannot honour.
  if (DIGIT_TICKS < 2) begin : g_bad_digit_ticks
    $error("seg7_scan_driver: DIGIT_TICKS must be >= 2");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
    $error("seg7_scan_driver: BLINK_FRAMES must be >= 1");
  end

  // BCD to active-low segments; codes 10..15 are shown as a dash so a
  // corrupted digit is visible rather than silently rendered as garbage.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [1:0]         idx_q, idx_d;            // scan slot, 0 = seg4 ... 3 = seg1
  logic               frame_tick_q, frame_tick_d;
  logic               first_q, first_d;        // set until the first clock after reset
  logic [3:0][3:0]    shadow_q, shadow_d;      // indexed by scan slot
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               phase_on_q, phase_on_d;  // blink phase, 1 = lit
  logic [3:0]         an_q, an_d;
  logic [6:0]         cathode_q, cathode_d;
  logic               dp_q, dp_d;

  logic               tick_wrap;
  logic               frame_bnd;
  logic [3:0]         digit;
  logic               lz_blank;
  logic               lit;

  // ---------------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------------

  // Advance the per-digit tick counter and step the slot on every wrap.
  always_comb begin
    tick_wrap    = (tick_q == TICK_LAST);
    frame_bnd    = tick_wrap && (idx_q == 2'd3);
    tick_d       = tick_wrap ? '0 : tick_q + 1'b1;
    idx_d        = tick_wrap ? idx_q + 2'd1 : idx_q;
    frame_tick_d = frame_bnd;
  end

  // Scan counters and the frame pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_q       <= '0;
      idx_q        <= 2'd0;
      frame_tick_q <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame-synchronous digit capture
  // ---------------------------------------------------------------------------

  // Latch all four digits together so a frame never mixes old and new time;
  // the extra load right after reset gets real digits on screen within a frame.
  always_comb begin
    shadow_d = shadow_q;
    first_d  = 1'b0;
    if (frame_bnd || first_q) begin
      shadow_d = {seg1, seg2, seg3, seg4};
    end
  end

  // Shadow digit registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_q <= '0;
      first_q  <= 1'b1;
    end else begin
      shadow_q <= shadow_d;
      first_q  <= first_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink phase
  // ---------------------------------------------------------------------------

  // Count frames while blinking; disabling blink parks the phase at ON so the
  // next enable always begins with a lit half-period.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_on_d  = phase_on_q;
    if (!blink_en) begin
      frame_cnt_d = '0;
      phase_on_d  = 1'b1;
    end else if (frame_bnd) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        phase_on_d  = ~phase_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt_q <= '0;
      phase_on_q  <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_on_q  <= phase_on_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pin generation
  // ---------------------------------------------------------------------------

  // Build the next pin pattern from the current slot; overrides are applied in
  // rising priority: leading-zero blank, blink OFF phase, display disable.
  // The phase is qualified with blink_en directly so dropping blink relights
  // the display on the very next clock instead of waiting for phase_on_q.
  always_comb begin
    digit     = shadow_q[idx_q];
    lz_blank  = blank_lz && (idx_q == 2'd3) && (digit == 4'd0);
    lit       = phase_on_q || !blink_en;
    an_d      = ~(4'b0001 << idx_q);
    cathode_d = bcd_to_seg(digit);
    dp_d      = ~(dp_en && (idx_q == 2'd2));
    if (lz_blank) begin
      an_d      = AN_DARK;
      cathode_d = SEG_DARK;
    end
    if (!lit) begin
      an_d = AN_DARK;
      dp_d = 1'b1;
    end
    if (!display_en) begin
      an_d      = AN_DARK;
      cathode_d = SEG_DARK;
      dp_d      = 1'b1;
    end
  end

  // Registered pins; reset darkens the display without waiting for a clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      an_q      <= AN_DARK;
      cathode_q <= SEG_DARK;
      dp_q      <= 1'b1;
    end else begin
      an_q      <= an_d;
      cathode_q <= cathode_d;
      dp_q      <= dp_d;
    end
  end

  assign an         = an_q;
  assign cathode    = cathode_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Purpose: scoreboard bench for seg7_scan_driver with DIGIT_TICKS=4, BLINK_FRAMES=2.
// Latency: expectations are tagged with the bench cycle at which the pins must show them.
// Backpressure: none; a monitor pops and compares on every falling edge whose cycle is due.
module tb_seg7_scan_driver;

  localparam int DT = 4;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] seg1, seg2, seg3, seg4;
  logic       display_en, dp_en, blank_lz, blink_en;
  logic [3:0] an;
  logic [6:0] cathode;
  logic       dp;
  logic       frame_tick;

  seg7_scan_driver #(
    .DIGIT_TICKS  (DT),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .seg1       (seg1),
    .seg2       (seg2),
    .seg3       (seg3),
    .seg4       (seg4),
    .display_en (display_en),
    .dp_en      (dp_en),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .an         (an),
    .cathode    (cathode),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [63:0] tag;
    logic [3:0]  an;
    logic [6:0]  cat;
    logic        dp;
    logic        ft;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Hand-entered segment table (active-low {g..a}).
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [3:0] anode_of(input logic [1:0] slot);
    case (slot)
      2'd0: return 4'b1110;
      2'd1: return 4'b1101;
      2'd2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic compare(input exp_t e);
    n_vec++;
    if (an !== e.an || cathode !== e.cat || dp !== e.dp || frame_tick !== e.ft) begin
      n_err++;
      $display("FAIL %s cyc=%0d got an=%b cat=%b dp=%b ft=%b want an=%b cat=%b dp=%b ft=%b",
               e.tag, cyc, an, cathode, dp, frame_tick, e.an, e.cat, e.dp, e.ft);
    end
  endtask

  task automatic push_one(input int at, input logic [63:0] tag, input logic [3:0] a,
                          input logic [6:0] c, input logic d, input logic f);
    exp_t e;
    e.cyc = at; e.tag = tag; e.an = a; e.cat = c; e.dp = d; e.ft = f;
    exp_q.push_back(e);
  endtask

  // Expected pins for the 16 cycles after a frame pulse seen at cycle base.
  // Digits are the shadow contents latched at base; dark_n leading cycles are in blink-OFF.
  task automatic push_frame(input int base, input logic [3:0] s1, input logic [3:0] s2,
                            input logic [3:0] s3, input logic [3:0] s4, input logic dpen,
                            input logic blz, input logic en, input int dark_n);
    logic [3:0] dig [4];
    logic [1:0] slot;
    exp_t       e;
    dig[0] = s4; dig[1] = s3; dig[2] = s2; dig[3] = s1;
    for (int k = 1; k <= 16; k++) begin
      slot  = 2'((k - 1) / 4);
      e.cyc = base + k;
      e.tag = "scan";
      e.ft  = (k == 16);
      e.an  = anode_of(slot);
      e.cat = seg_of(dig[slot]);
      e.dp  = !(dpen && slot == 2'd2);
      if (blz && slot == 2'd3 && dig[slot] == 4'd0) begin
        e.an  = 4'b1111;
        e.cat = 7'b1111111;
      end
      if (k <= dark_n) begin
        e.an = 4'b1111;
        e.dp = 1'b1;
      end
      if (!en) begin
        e.an  = 4'b1111;
        e.cat = 7'b1111111;
        e.dp  = 1'b1;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_ft(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Monitor: compares every expectation due at this falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        if (e.cyc < cyc) begin
          n_vec++;
          n_err++;
          $display("FAIL %s expected at cyc=%0d but not sampled (now %0d)", e.tag, e.cyc, cyc);
        end else begin
          compare(e);
        end
      end
    end
  end

  // Stimulus.
  initial begin : stim
    int   r, c, ft_at;
    exp_t e;

    resetn = 1'b0;
    seg1 = 4'd1; seg2 = 4'd2; seg3 = 4'd3; seg4 = 4'd4;
    display_en = 1'b1; dp_en = 1'b0; blank_lz = 1'b0; blink_en = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    e.cyc = cyc; e.tag = "reset"; e.an = 4'b1111; e.cat = 7'b1111111; e.dp = 1'b1; e.ft = 1'b0;
    compare(e);

    // Release: first slot shows shadow 0, then the digits latched on the first clock.
    r = cyc;
    resetn = 1'b1;
    push_one(r + 1, "boot", 4'b1110, 7'b1000000, 1'b1, 1'b0);
    push_one(r + 2, "boot", 4'b1110, 7'b0011001, 1'b1, 1'b0);
    push_one(r + 4, "boot", 4'b1110, 7'b0011001, 1'b1, 1'b0);
    push_one(r + 5, "boot", 4'b1101, 7'b0110000, 1'b1, 1'b0);

    wait_ft(ft_at);
    n_vec++;
    if (ft_at != r + 16) begin
      n_err++;
      $display("FAIL first_frame_tick at cyc=%0d want %0d", ft_at, r + 16);
    end
    if (ft_at < 0) begin
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
    c = ft_at;

    // Normal scan, then seg4 4->7 during its own slot: visible only after the next latch.
    push_frame(c,      4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b1, 0);
    push_frame(c + 16, 4'd1, 4'd2, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 0);
    wait_cyc(c + 2);
    seg4 = 4'd7;

    // Leading-zero blank and decimal point; seg1=0 reaches the shadow one frame later.
    wait_cyc(c + 32);
    c = c + 32;
    seg1 = 4'd0; blank_lz = 1'b1; dp_en = 1'b1;
    push_frame(c,      4'd1, 4'd2, 4'd3, 4'd7, 1'b1, 1'b1, 1'b1, 0);
    push_frame(c + 16, 4'd0, 4'd2, 4'd3, 4'd7, 1'b1, 1'b1, 1'b1, 0);

    // Blink: two lit frames, two dark frames; blink dropped mid dark frame.
    wait_cyc(c + 32);
    c = c + 32;
    blink_en = 1'b1; blank_lz = 1'b0; dp_en = 1'b0; seg1 = 4'd1;
    push_frame(c,      4'd0, 4'd2, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 0);
    push_frame(c + 16, 4'd1, 4'd2, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 0);
    push_frame(c + 32, 4'd1, 4'd2, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 16);
    push_frame(c + 48, 4'd1, 4'd2, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 5);
    wait_cyc(c + 53);
    blink_en = 1'b0;

    // Non-BCD digit shows a dash; display_en=0 darkens pins while frame_tick runs.
    wait_cyc(c + 64);
    c = c + 64;
    seg3 = 4'hC;
    push_frame(c,      4'd1, 4'd2, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 0);
    push_frame(c + 16, 4'd1, 4'd2, 4'hC, 4'd7, 1'b0, 1'b0, 1'b1, 0);
    wait_cyc(c + 32);
    display_en = 1'b0;
    push_frame(c + 32, 4'd1, 4'd2, 4'hC, 4'd7, 1'b0, 1'b0, 1'b0, 0);
    wait_cyc(c + 48);
    display_en = 1'b1;
    push_one(c + 49, "relit", 4'b1110, 7'b1111000, 1'b1, 1'b0);
    push_one(c + 54, "prerst", 4'b1101, 7'b0111111, 1'b1, 1'b0);

    // Asynchronous reset mid-slot: pins must go dark before any clock edge.
    wait_cyc(c + 54);
    #2;
    resetn = 1'b0;
    #1;
    e.cyc = cyc; e.tag = "arst"; e.an = 4'b1111; e.cat = 7'b1111111; e.dp = 1'b1; e.ft = 1'b0;
    compare(e);
    repeat (2) @(negedge clk);
    e.tag = "rsthold";
    compare(e);

    r = cyc;
    resetn = 1'b1;
    push_one(r + 1, "reboot", 4'b1110, 7'b1000000, 1'b1, 1'b0);
    push_one(r + 2, "reboot", 4'b1110, 7'b1111000, 1'b1, 1'b0);
    push_one(r + 4, "reboot", 4'b1110, 7'b1111000, 1'b1, 1'b0);
    push_one(r + 5, "reboot", 4'b1101, 7'b0111111, 1'b1, 1'b0);

    // Drain the scoreboard; anything left over was never seen.
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s expected at cyc=%0d never compared", e.tag, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
